// File: rtl/led_sequencer_if.sv
// Pattern-select / LED-drive bundle for led_sequencer.
// The duty field exists only when LED_SEQ_PWM_EN is defined.
interface led_sequencer_if #(
  parameter int LEDS     = 3,
  parameter int PWM_BITS = 4
);
  logic [2:0]          sel;
  logic                hold;
`ifdef LED_SEQ_PWM_EN
  logic [PWM_BITS-1:0] duty;
`endif
  logic [LEDS-1:0]     led;

  modport master (
    output sel,
    output hold,
`ifdef LED_SEQ_PWM_EN
    output duty,
`endif
    input  led
  );

  modport slave (
    input  sel,
    input  hold,
`ifdef LED_SEQ_PWM_EN
    input  duty,
`endif
    output led
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern generator: eight patterns stepped once per 2^DIV_BITS clocks via a tick enable.
// Define LED_SEQ_PWM_EN to add duty-cycle brightness gating of the registered LED drive.
module led_sequencer #(
  parameter int LEDS     = 3,
  parameter int DIV_BITS = 21,
  parameter int PWM_BITS = 4
) (
  input  logic          clock,
  input  logic          reset,
  led_sequencer_if.slave bus_if
);

  localparam logic [2:0] MODE_JOHNSON     = 3'd0;
  localparam logic [2:0] MODE_JOHNSON_INV = 3'd1;
  localparam logic [2:0] MODE_ALL_OFF     = 3'd2;
  localparam logic [2:0] MODE_ALL_ON      = 3'd3;
  localparam logic [2:0] MODE_BINARY      = 3'd4;
  localparam logic [2:0] MODE_BOUNCE      = 3'd5;
  localparam logic [2:0] MODE_ROTATE      = 3'd6;
  localparam logic [2:0] MODE_FLASH       = 3'd7;

  localparam int            PW       = (LEDS > 1) ? $clog2(LEDS) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(LEDS - 1);

  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic [2:0]          sel_q;
  logic [LEDS-1:0]     s_q, s_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic                dir_down_q, dir_down_d;
  logic [LEDS-1:0]     led_q, led_d;
  logic [LEDS-1:0]     johnson, onehot, pattern;
  logic                change, tick;

  assign change = (bus_if.sel != sel_q);
  assign tick   = (&presc_q) & ~bus_if.hold;

  always_comb begin
    johnson    = '0;
    johnson[0] = ~s_q[LEDS-1];
    for (int i = 1; i < LEDS; i++) johnson[i] = s_q[i-1];
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < LEDS; i++) onehot[i] = (pos_q == PW'(i));
  end

  // A mode change wins over a coincident tick and restarts the prescaler.
  always_comb begin
    presc_d    = presc_q;
    s_d        = s_q;
    pos_d      = pos_q;
    dir_down_d = dir_down_q;
    if (change) begin
      presc_d    = '0;
      s_d        = '0;
      pos_d      = '0;
      dir_down_d = 1'b0;
    end else if (!bus_if.hold) begin
      presc_d = presc_q + DIV_BITS'(1);
      if (tick) begin
        case (sel_q)
          MODE_JOHNSON, MODE_JOHNSON_INV: s_d = johnson;
          MODE_BINARY:                    s_d = s_q + LEDS'(1);
          MODE_FLASH:                     s_d = ~s_q;
          MODE_ROTATE: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
          MODE_BOUNCE: begin
            if (LEDS > 1) begin
              if (!dir_down_q) begin
                if (pos_q == POS_LAST) begin
                  dir_down_d = 1'b1;
                  pos_d      = pos_q - PW'(1);
                end else begin
                  pos_d = pos_q + PW'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  dir_down_d = 1'b0;
                  pos_d      = pos_q + PW'(1);
                end else begin
                  pos_d = pos_q - PW'(1);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (sel_q)
      MODE_JOHNSON_INV:         pattern = ~s_q;
      MODE_ALL_OFF:             pattern = '0;
      MODE_ALL_ON:              pattern = '1;
      MODE_BOUNCE, MODE_ROTATE: pattern = onehot;
      default:                  pattern = s_q;
    endcase
  end

`ifdef LED_SEQ_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                bright;

  assign bright = (pwm_cnt_q < bus_if.duty) | (&bus_if.duty);
  assign led_d  = pattern & {LEDS{bright}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
  end
`else
  assign led_d = pattern;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      sel_q      <= '0;
      s_q        <= '0;
      pos_q      <= '0;
      dir_down_q <= 1'b0;
      led_q      <= '0;
    end else begin
      presc_q    <= presc_d;
      sel_q      <= bus_if.sel;
      s_q        <= s_d;
      pos_q      <= pos_d;
      dir_down_q <= dir_down_d;
      led_q      <= led_d;
    end
  end

  assign bus_if.led = led_q;

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Parametrised LED pattern generator for board bring-up and status display. It generalises the fixed 3-LED Johnson blinker to LEDS outputs and a programmable tick rate, with eight selectable patterns. It runs entirely in the single clock domain, using a tick enable rather than a derived clock. It drives board LED pins directly from registers.

Parameters:
LEDS, 3, number of LED outputs (>=1)
DIV_BITS, 21, prescaler width; one pattern step every 2^DIV_BITS clocks
PWM_BITS, 4, width of brightness counter and duty input (used only with LED_SEQ_PWM_EN)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
sel  input  3  pattern select, sampled every clock
hold  input  1  1 = freeze prescaler (pattern stops, output stays)
duty  input  PWM_BITS  brightness (present only with LED_SEQ_PWM_EN)
led  output  LEDS  registered LED drive, bit 0 = first LED

Behaviour:
- Reset (async assert, sync release): led=0, pattern state s=0, prescaler=0, pos=0, dir=up, sel_q=0.
- Prescaler: free-running DIV_BITS counter, +1 per clock unless hold=1. tick=1 in the cycle the counter is all-ones, then it wraps to 0. Tick period is 2^DIV_BITS clocks.
- sel_q: registers sel each clock. If sel != sel_q (mode change):
  - s, pos and dir load the new mode's initial values (s=0, pos=0, dir=up).
  - prescaler clears to 0.
  - a tick in that same cycle is ignored.
  - change takes priority over tick.
- Pattern update on tick (LEDS-bit state s):
  - sel=0 Johnson: s[0]<=~s[LEDS-1], s[i]<=s[i-1]; period 2*LEDS ticks; led=s.
  - sel=1 inverted Johnson: same s sequence; led=~s.
  - sel=2 all off: led=0; s frozen.
  - sel=3 all on: led=all-ones; s frozen.
  - sel=4 binary up counter: s<=s+1, wraps mod 2^LEDS; led=s.
  - sel=5 bounce: one-hot at pos.
    - dir=up: pos increments; at pos=LEDS-1 dir flips to down and pos decrements on the next tick.
    - dir=down mirrors this at pos=0.
    - period 2*(LEDS-1) ticks; LEDS=1: led=1 constant.
  - sel=6 rotate: one-hot at pos; pos<=pos+1, wraps LEDS-1 -> 0.
  - sel=7 flash: s<=~s (all bits together); led=s.
- Output latency:
  - led is registered from current s/pos/sel_q, so it reflects a state update 1 clock after the tick.
  - after a sel change, led shows the new mode's reset-state pattern 2 clocks after sel changes: 1 clock for sel_q, 1 for led.
- hold=1:
  - prescaler, s and pos frozen; led keeps its current value.
  - a mode change under hold still reinitialises s, pos and prescaler.
- Widths:
  - pos is clog2(LEDS) bits, minimum 1.
  - LEDS=1: Johnson toggles each tick; rotate is constant on.
- Reset mid-pattern returns to the reset values immediately; no output glitch beyond the async clear to 0.

Optional Feature:
LED_SEQ_PWM_EN
- Defined:
  - adds the duty port and a free-running PWM_BITS counter pwm_cnt (reset 0, not affected by hold).
  - led = pattern & {LEDS{(pwm_cnt < duty) | (&duty)}}, registered.
  - duty=0 gives all LEDs dark; duty all-ones gives full on.
  - duty is sampled every clock.
- Undefined: duty port and pwm_cnt absent; led = pattern ungated.

Test Plan:
(All with LEDS=3, DIV_BITS=2, so one tick every 4 clocks.)
- Reset, sel=0 for 28 clocks -> led steps every 4 clocks: 000,001,011,111,110,100,000 (period 6 ticks).
- Sel 0 -> 1 mid-sequence at s=011 -> led=111 (~000) 2 clocks after the change; prescaler restarts, so the next step comes 4 clocks later -> 110.
- Sel=5 from reset -> pos 0,1,2,1,0,1: led 001,010,100,010,001,010; sel=6 -> 001,010,100,001.
- Sel=4, 9 ticks -> led 001..111,000,001 (wrap); raise hold for 10 clocks -> led constant; release -> count resumes from the held value.
- Sel=3 then sel=2 -> led=111 then 000 within 2 clocks of each change; assert reset mid-sel=0 pattern -> led=000 immediately (asynchronous), sequence restarts at 001.
- LED_SEQ_PWM_EN, PWM_BITS=4, sel=3: duty=4 -> each led high 4 of every 16 clocks; duty=0 -> always 0; duty=15 -> always 1.
